// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared width and opcode definitions for the divide unit
package div_unit_pkg;

    localparam int XLEN = 32;

    // Encodings follow funct3[1:0] so the decoder can pass the field through untouched.
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import div_unit_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic [N-1:0] rem_i,
    input  logic [N-1:0] quot_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic [N-1:0] quot_o
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // The partial remainder stays below the divisor, so N+1 bits hold the shifted value
    // and the sign of the difference.
    always_comb begin
        shifted = {rem_i, quot_i[N-1]};
        diff    = shifted - {1'b0, divisor_i};
        if (!diff[N]) begin
            rem_o  = diff[N-1:0];
            quot_o = {quot_i[N-2:0], 1'b1};
        end else begin
            rem_o  = shifted[N-1:0];
            quot_o = {quot_i[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit with early special cases
module div_unit
    import div_unit_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  dvsr_q, dvsr_d;
    logic [N-1:0]  result_q, result_d;
    logic [1:0]    op_q, op_d;
    logic          sa_q, sa_d;
    logic          sb_q, sb_d;

    logic          in_signed;
    logic          a_neg, b_neg;
    logic [N-1:0]  mag_a, mag_b;
    logic          div_zero, sgn_ovf;
    logic [N-1:0]  rem_nx, quot_nx;
    logic [N-1:0]  q_fix, r_fix;

    assign in_signed = op_is_signed(op);
    assign a_neg     = in_signed & a[N-1];
    assign b_neg     = in_signed & b[N-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;
    assign div_zero  = (b == '0);
    assign sgn_ovf   = in_signed && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);

    // Signs are only latched for signed ops, so they directly drive the fix-up.
    assign q_fix = (sa_q ^ sb_q) ? -quot_q : quot_q;
    assign r_fix = sa_q ? -rem_q : rem_q;

    div_step #(.N(N)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvsr_q),
        .rem_o     (rem_nx),
        .quot_o    (quot_nx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op;
                    sa_d   = a_neg;
                    sb_d   = b_neg;
                    dvsr_d = mag_b;
                    quot_d = mag_a;
                    rem_d  = '0;
                    cnt_d  = CW'(N-1);
                    if (div_zero) begin
                        result_d = op_is_rem(op) ? a : '1;
                        state_d  = S_DONE;
                    end else if (sgn_ovf) begin
                        result_d = op_is_rem(op) ? '0 : a;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d  = rem_nx;
                quot_d = quot_nx;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                result_d = op_is_rem(op_q) ? r_fix : q_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && rst_n;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit against an arithmetic model
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [1:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;

    always #5 clk = ~clk;

    div_unit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t expq[$];
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   hold_ready = 1'b0;
    bit   first_seen = 1'b0;
    bit   chk_ready_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V M semantics straight from the definition: 64-bit arithmetic truncates toward zero.
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (o[0]) begin
            sx = longint'(x);
            sy = longint'(y);
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        q = sx / sy;
        r = sx % sy;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return N + 2;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_r, input int exp_l);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("issue_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        expq.push_back('{exp_r, exp_l, cyc});
        in_valid = 1'b0;
        a = 32'($urandom);
        b = 32'($urandom);
        op = 2'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((expq.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) check("drain_timeout", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (chk_ready_next) begin
                    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
                    chk_ready_next = 1'b0;
                end
                if (out_valid) begin
                    check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                    if (expq.size() == 0) begin
                        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                    end else begin
                        if (!first_seen) begin
                            first_seen = 1'b1;
                            check("latency", 32'(cyc - expq[0].acc + 1), 32'(expq[0].lat));
                        end
                        check("result", result, expq[0].res);
                        if (out_ready) begin
                            void'(expq.pop_front());
                            first_seen = 1'b0;
                            chk_ready_next = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        int n;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        check("model_div_20_m3", ref_res(DIV_OP_DIV, 32'd20, 32'hFFFF_FFFD), 32'hFFFF_FFFA);
        check("model_rem_m20_3", ref_res(DIV_OP_REM, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
        check("model_div_ovf", ref_res(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("model_rem_ovf", ref_res(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

        issue(DIV_OP_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
        issue(DIV_OP_REM,  32'd20,        32'hFFFF_FFFD, 32'd2,         34);
        issue(DIV_OP_REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 34);
        issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 34);
        issue(DIV_OP_REMU, 32'hFFFF_FFFF, 32'd2,         32'd1,         34);
        issue(DIV_OP_DIVU, 32'd5,         32'd7,         32'd0,         34);
        issue(DIV_OP_REMU, 32'd5,         32'd7,         32'd5,         34);
        issue(DIV_OP_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 1);
        issue(DIV_OP_REMU, 32'd7,         32'd0,         32'd7,         1);
        issue(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        issue(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34);
        wait_done();

        hold_ready = 1'b1;
        issue(DIV_OP_DIV, 32'd100, 32'd7, 32'd14, 34);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        hold_ready = 1'b0;
        issue(DIV_OP_REM, 32'd100, 32'd7, 32'd2, 34);
        wait_done();

        issue(DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 34);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(expq.pop_front());
        first_seen = 1'b0;
        @(negedge clk);
        check("in_ready_after_flush", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);

        in_valid = 1'b1;
        flush = 1'b1;
        op = DIV_OP_DIV;
        a = 32'd7;
        b = 32'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_blocks_accept", {31'd0, in_ready}, 32'd1);
        repeat (10) @(negedge clk);

        issue(DIV_OP_DIV, 32'd12345, 32'd7, 32'd1763, 34);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        void'(expq.pop_front());
        first_seen = 1'b0;
        check("midcalc_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midcalc_reset_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom);
            rx = rand_operand();
            ry = rand_operand();
            issue(ro, rx, ry, ref_res(ro, rx, ry), ref_lat(ro, rx, ry));
        end
        wait_done();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
